// File: rtl/bongo_hit_scheduler.sv
// Bongo hit scheduler: edge-detects sensor hits and feeds one shared drum-voice engine.
// Optional per-channel grant counters are built when HIT_STATS_EN is defined.
module bongo_hit_scheduler #(
   parameter int GAP_CYC  = 250000,
   parameter int PLAY_MAX = 2500000,
   parameter int CW       = 22
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  bongo_hit,
   input  logic [1:0]  ch_enable,
   input  logic        eng_done,
   output logic        eng_start,
   output logic        eng_ch,
   output logic        sched_busy,
   output logic [1:0]  pending,
   output logic        overrun,
   output logic        timeout,
   output logic [15:0] hits_l,
   output logic [15:0] hits_r
);

   typedef enum logic [1:0] {
      IDLE,
      START,
      PLAY,
      GAP
   } state_t;

   localparam logic [CW-1:0] PLAY_LAST = CW'(PLAY_MAX - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);

   state_t        state, state_nx;
   logic [1:0]    prev;
   logic [1:0]    rise;
   logic [1:0]    clr;
   logic [1:0]    pend_nx;
   logic          grant, grant_nx;
   logic          rr;
   logic [CW-1:0] cnt, cnt_nx;
   logic          to_set;
   logic          ovr_set;

   assign eng_start  = (state == START);
   assign eng_ch     = grant;
   assign sched_busy = (state != IDLE);

   // A rise on the channel being cleared this cycle re-arms it without overrun.
   always_comb begin
      rise    = bongo_hit & ~prev & ch_enable;
      clr     = (state == START) ? (2'b01 << grant) : 2'b00;
      pend_nx = (pending & ~clr) | rise;
      ovr_set = |(rise & pending & ~clr);
   end

   always_comb begin
      state_nx = state;
      grant_nx = grant;
      cnt_nx   = cnt;
      to_set   = 1'b0;
      case (state)
         IDLE: begin
            if (pending != 2'b00) begin
               state_nx = START;
               grant_nx = (pending == 2'b11) ? rr : pending[1];
            end
         end
         START: begin
            state_nx = PLAY;
            cnt_nx   = '0;
         end
         PLAY: begin
            if (eng_done) begin
               state_nx = GAP;
               cnt_nx   = '0;
            end else if (cnt == PLAY_LAST) begin
               state_nx = GAP;
               cnt_nx   = '0;
               to_set   = 1'b1;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         GAP: begin
            if (cnt == GAP_LAST) begin
               state_nx = IDLE;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // rr holds the channel preferred on the next tie.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         prev    <= 2'b00;
         pending <= 2'b00;
         grant   <= 1'b0;
         rr      <= 1'b0;
         cnt     <= '0;
         overrun <= 1'b0;
         timeout <= 1'b0;
      end else begin
         state   <= state_nx;
         prev    <= bongo_hit;
         pending <= pend_nx;
         grant   <= grant_nx;
         cnt     <= cnt_nx;
         if (ovr_set) overrun <= 1'b1;
         if (to_set) timeout <= 1'b1;
         if (state == START) rr <= ~grant;
      end
   end

`ifdef HIT_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         hits_l <= 16'h0000;
         hits_r <= 16'h0000;
      end else if (state == START) begin
         if (grant) begin
            if (hits_r != 16'hFFFF) hits_r <= hits_r + 16'd1;
         end else begin
            if (hits_l != 16'hFFFF) hits_l <= hits_l + 16'd1;
         end
      end
   end
`else
   assign hits_l = 16'h0000;
   assign hits_r = 16'h0000;
`endif

endmodule

// File: tb/tb_bongo_hit_scheduler.sv
// Bench for bongo_hit_scheduler: timeline-based reference model plus directed
// literal checks, followed by randomized traffic.
module tb_bongo_hit_scheduler;

   localparam int GAP_CYC  = 4;
   localparam int PLAY_MAX = 16;
   localparam int P_IDLE = 0, P_START = 1, P_PLAY = 2, P_GAP = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  bongo_hit = 2'b00;
   logic [1:0]  ch_enable = 2'b11;
   logic        eng_done = 1'b0;
   logic        eng_start, eng_ch, sched_busy, overrun, timeout;
   logic [1:0]  pending;
   logic [15:0] hits_l, hits_r;

   int total = 0;
   int bad = 0;
   bit armed = 0;

   // Reference model: a note is a timeline of absolute cycle numbers.
   int         cyc = 0;
   int         t_start = -1;
   int         t_end = -1;
   logic [1:0] m_pend = 0, m_prev = 0;
   logic       m_ovr = 0, m_to = 0, m_g = 0, m_pref = 0;
   int         m_hl = 0, m_hr = 0;

   bongo_hit_scheduler #(
      .GAP_CYC(GAP_CYC), .PLAY_MAX(PLAY_MAX), .CW(8)
   ) dut (
      .clk(clk), .rst(rst), .bongo_hit(bongo_hit),
      .ch_enable(ch_enable), .eng_done(eng_done),
      .eng_start(eng_start), .eng_ch(eng_ch),
      .sched_busy(sched_busy), .pending(pending),
      .overrun(overrun), .timeout(timeout),
      .hits_l(hits_l), .hits_r(hits_r)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int phase(input int c);
      if (t_start < 0 || c < t_start) return P_IDLE;
      if (c == t_start) return P_START;
      if (t_end < 0 || c <= t_end) return P_PLAY;
      if (c <= t_end + GAP_CYC) return P_GAP;
      return P_IDLE;
   endfunction

   always @(posedge clk) begin
      int ph;
      logic [1:0] rise, clr;
      ph = phase(cyc);
      if (rst) begin
         m_pend = 0; m_prev = 0; m_ovr = 0; m_to = 0;
         m_g = 0; m_pref = 0; t_start = -1; t_end = -1;
         m_hl = 0; m_hr = 0;
      end else begin
         rise = bongo_hit & ~m_prev & ch_enable;
         clr = 2'b00;
         if (ph == P_START) begin
            clr[m_g] = 1'b1;
            m_pref = ~m_g;
            if (m_g) m_hr = (m_hr < 65535) ? m_hr + 1 : m_hr;
            else     m_hl = (m_hl < 65535) ? m_hl + 1 : m_hl;
         end
         if ((rise & m_pend & ~clr) != 2'b00) m_ovr = 1;
         if (ph == P_IDLE && m_pend != 2'b00) begin
            m_g = (m_pend == 2'b11) ? m_pref : m_pend[1];
            t_start = cyc + 1;
            t_end = -1;
         end
         if (ph == P_PLAY && t_end < 0) begin
            if (eng_done) t_end = cyc;
            else if (cyc - t_start == PLAY_MAX) begin
               t_end = cyc;
               m_to = 1;
            end
         end
         m_pend = (m_pend & ~clr) | rise;
         m_prev = bongo_hit;
      end
      cyc++;
   end

   always @(negedge clk) begin
      int ph;
      if (armed) begin
         ph = phase(cyc);
         chk("eng_start", eng_start, ph == P_START);
         chk("sched_busy", sched_busy, ph != P_IDLE);
         chk("eng_ch", eng_ch, m_g);
         chk("pending", pending, m_pend);
         chk("overrun", overrun, m_ovr);
         chk("timeout", timeout, m_to);
`ifdef HIT_STATS_EN
         chk("hits_l", hits_l, m_hl);
         chk("hits_r", hits_r, m_hr);
`else
         chk("hits_l", hits_l, 0);
         chk("hits_r", hits_r, 0);
`endif
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset(input int n);
      rst = 1; bongo_hit = 2'b00; eng_done = 0; ch_enable = 2'b11;
      repeat (n) tick();
      rst = 0;
   endtask

   task automatic wait_start();
      int n = 0;
      while (!eng_start && n < 80) begin
         tick();
         n++;
      end
      if (!eng_start) chk("wait_start_timeout", 0, 1);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (sched_busy && n < 80) begin
         tick();
         n++;
      end
      if (sched_busy) chk("wait_idle_timeout", 1, 0);
   endtask

   task automatic finish_note();
      tick();
      eng_done = 1;
      tick();
      eng_done = 0;
      wait_idle();
   endtask

   initial begin
      int n;
      // 1) reset values and first-grant latency
      do_reset(3);
      chk("rst_pending", pending, 0);
      chk("rst_start", eng_start, 0);
      chk("rst_busy", sched_busy, 0);
      chk("rst_flags", {overrun, timeout, eng_ch}, 0);
      chk("rst_hits", hits_l | hits_r, 0);
      armed = 1;
      tick();
      bongo_hit = 2'b01;
      tick();
      chk("lat_pending", pending, 1);
      chk("lat_no_start", eng_start, 0);
      tick();
      chk("lat_start", eng_start, 1);
      chk("lat_ch", eng_ch, 0);
      finish_note();

      // 2) tie arbitration and round robin
      do_reset(1);
      bongo_hit = 2'b11;
      wait_start();
      chk("tie1_ch", eng_ch, 0);
      tick();
      bongo_hit = 2'b10;
      tick();
      bongo_hit = 2'b11;
      tick();
      eng_done = 1;
      tick();
      eng_done = 0;
      wait_idle();
      wait_start();
      chk("tie2_ch", eng_ch, 1);
      finish_note();
      wait_start();
      chk("tie3_ch", eng_ch, 0);
      finish_note();

      // 3) timeout: START + 16 PLAY + 4 GAP busy cycles
      do_reset(1);
      bongo_hit = 2'b01;
      wait_start();
      n = 0;
      while (sched_busy && n < 60) begin
         tick();
         n++;
      end
      chk("timeout_len", n, 21);
      chk("timeout_flag", timeout, 1);

      // 4) overrun, coincident re-arm, disabled channels
      do_reset(1);
      bongo_hit = 2'b10;
      wait_start();
      tick();
      bongo_hit = 2'b11;
      tick();
      bongo_hit = 2'b10;
      tick();
      bongo_hit = 2'b11;
      tick();
      chk("overrun_set", overrun, 1);
      eng_done = 1;
      tick();
      eng_done = 0;
      wait_idle();
      wait_start();
      chk("overrun_ch", eng_ch, 0);
      finish_note();
      repeat (6) tick();
      do_reset(1);
      bongo_hit = 2'b01;
      tick();
      bongo_hit = 2'b00;
      tick();
      bongo_hit = 2'b01;
      chk("coin_start", eng_start, 1);
      tick();
      chk("coin_pending", pending, 1);
      chk("coin_overrun", overrun, 0);
      finish_note();
      wait_start();
      chk("coin_second", eng_ch, 0);
      finish_note();
      do_reset(1);
      ch_enable = 2'b00;
      bongo_hit = 2'b11;
      repeat (3) tick();
      chk("dis_pending", pending, 0);
      chk("dis_busy", sched_busy, 0);
      ch_enable = 2'b11;

      // 5) reset during PLAY with right pending
      do_reset(1);
      bongo_hit = 2'b01;
      wait_start();
      tick();
      bongo_hit = 2'b11;
      tick();
      chk("r5_pending", pending, 2);
      rst = 1;
      bongo_hit = 2'b00;
      tick();
      rst = 0;
      chk("r5_busy", sched_busy, 0);
      chk("r5_pend0", pending, 0);
      n = 0;
      repeat (10) begin
         tick();
         n += eng_start;
      end
      chk("r5_no_start", n, 0);

      // 6) grant statistics
      do_reset(1);
      for (int i = 0; i < 5; i++) begin
         bongo_hit = (i < 3) ? 2'b01 : 2'b10;
         wait_start();
         bongo_hit = 2'b00;
         finish_note();
      end
`ifdef HIT_STATS_EN
      chk("stats_l", hits_l, 3);
      chk("stats_r", hits_r, 2);
      force dut.hits_l = 16'hFFFF;
      m_hl = 65535;
      tick();
      release dut.hits_l;
      bongo_hit = 2'b01;
      wait_start();
      bongo_hit = 2'b00;
      finish_note();
      chk("stats_sat", hits_l, 16'hFFFF);
`else
      chk("stats_l_off", hits_l, 0);
      chk("stats_r_off", hits_r, 0);
`endif

      // randomized traffic against the model
      do_reset(1);
      for (int i = 0; i < 4000; i++) begin
         tick();
         rst = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 3) == 0) bongo_hit[0] = ~bongo_hit[0];
         if ($urandom_range(0, 3) == 0) bongo_hit[1] = ~bongo_hit[1];
         ch_enable = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b11;
         eng_done = ($urandom_range(0, 11) == 0);
      end
      rst = 0;
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
